// File: rtl/rx_pkg.sv
// Shared definitions for the serial receive path.
//   rx_state_t         - sequencer FSM state encoding (3 bits, six states)
//   RX_TIMEOUT_DEFAULT - default watchdog limit, in clocks, for the RECEIVE state
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    RECEIVE  = 3'd2,
    STOP_SET = 3'd3,
    STOP_CHK = 3'd4,
    LOAD     = 3'd5
  } rx_state_t;

  localparam int RX_TIMEOUT_DEFAULT = 120;

endpackage

// File: rtl/rx_watchdog.sv
// Frame watchdog counter for the receive sequencer.
// Counts clocks while enabled and flags when the last allowed cycle is reached.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset, zeroes the count
//   clear   in  zeroes the count (held high whenever no frame is being received)
//   enable  in  advance the count by one per clock
//   expired out high while enabled and the count sits at LIMIT-1
module rx_watchdog
  import rx_pkg::*;
#(
  parameter int LIMIT = RX_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // The count holds at LAST instead of wrapping; the sequencer leaves
  // RECEIVE on that cycle anyway, so the hold only guards against a
  // stuck enable.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/rx_sequencer.sv
// Receive-side control unit of the serial receiver.
// Starts a frame on a start-bit pulse, runs the bit timer, checks the stop
// bit, commands the buffer load and maintains the host status flags.
// Ports:
//   clk                 in  system clock, rising edge
//   rst                 in  synchronous active-high reset
//   start_bit_detected  in  one-cycle pulse on the serial line falling edge
//   packet_done         in  one-cycle pulse from the bit timer after 9 bit periods
//   framing_error       in  stop-bit checker result, valid the cycle after sbc_enable
//   data_read           in  host read strobe, level-sampled
//   sbc_clear           out clears the stop-bit checker
//   sbc_enable          out latches the stop-bit checker
//   enable_timer        out runs the bit timer; low clears it
//   load_buffer         out one-cycle buffer load strobe
//   data_ready          out receive buffer holds unread data
//   overrun_error       out a frame was loaded over unread data (sticky)
//   timeout_error       out one-cycle pulse when the watchdog aborts a frame
module rx_sequencer
  import rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = RX_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start_bit_detected,
  input  logic packet_done,
  input  logic framing_error,
  input  logic data_read,
  output logic sbc_clear,
  output logic sbc_enable,
  output logic enable_timer,
  output logic load_buffer,
  output logic data_ready,
  output logic overrun_error,
  output logic timeout_error
);

  rx_state_t state;
  rx_state_t state_nxt;
  logic      wd_expired;
  logic      timeout_hit;
  logic      in_receive;
  logic      in_load;

  assign in_receive = (state == RECEIVE);
  assign in_load    = (state == LOAD);

  rx_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_receive),
    .enable  (in_receive),
    .expired (wd_expired)
  );

  // packet_done wins over an expiring watchdog in the same cycle.
  assign timeout_hit = in_receive && !packet_done && wd_expired;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_bit_detected) state_nxt = CLEAR;
      CLEAR:    state_nxt = RECEIVE;
      RECEIVE: begin
        if (packet_done)      state_nxt = STOP_SET;
        else if (wd_expired)  state_nxt = IDLE;
      end
      STOP_SET: state_nxt = STOP_CHK;
      STOP_CHK: state_nxt = framing_error ? IDLE : LOAD;
      LOAD:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one equals a plain
  // decode of the state register without any input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sbc_clear     <= 1'b0;
      sbc_enable    <= 1'b0;
      enable_timer  <= 1'b0;
      load_buffer   <= 1'b0;
      timeout_error <= 1'b0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      sbc_clear     <= (state_nxt == CLEAR);
      sbc_enable    <= (state_nxt == STOP_SET);
      enable_timer  <= (state_nxt == RECEIVE);
      load_buffer   <= (state_nxt == LOAD);
      timeout_error <= timeout_hit;

      // A load always leaves unread data behind, even if the host reads
      // in the same cycle (that read consumed the previous byte).
      if (in_load) begin
        data_ready <= 1'b1;
      end else if (data_read) begin
        data_ready <= 1'b0;
      end

      if (in_load && data_ready && !data_read) begin
        overrun_error <= 1'b1;
      end else if (data_read) begin
        overrun_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_sequencer.sv
module tb_rx_sequencer;

  localparam int T = 20;
  localparam int N = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_bit_detected = 1'b0;
  logic packet_done = 1'b0;
  logic framing_error = 1'b0;
  logic data_read = 1'b0;
  logic sbc_clear, sbc_enable, enable_timer, load_buffer;
  logic data_ready, overrun_error, timeout_error;

  always #5 clk = ~clk;

  rx_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_bit_detected (start_bit_detected),
    .packet_done        (packet_done),
    .framing_error      (framing_error),
    .data_read          (data_read),
    .sbc_clear          (sbc_clear),
    .sbc_enable         (sbc_enable),
    .enable_timer       (enable_timer),
    .load_buffer        (load_buffer),
    .data_ready         (data_ready),
    .overrun_error      (overrun_error),
    .timeout_error      (timeout_error)
  );

  // Per-cycle stimulus (sampled at the edge closing that cycle) and
  // per-cycle expected outputs (visible during that cycle).
  bit st_a[N], pd_a[N], fe_a[N], rd_a[N], rs_a[N];
  bit clr_e[N], sen_e[N], en_e[N], ld_e[N], to_e[N], rdy_e[N], ovr_e[N];

  int cursor;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic obs, input logic exp, input int c);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
    end
  endtask

  // Schedule one frame as a timeline. mode: 0 clean, 1 framing error,
  // 2 watchdog timeout, 3 reset during RECEIVE. d = RECEIVE cycles until
  // packet_done (modes 0/1) or until rst (mode 3). Returns the packet_done
  // cycle r (or -1).
  task automatic add_frame(input int mode, input int d, input int gap, output int r_out);
    int s, r, rx_hi, end_c;
    s = cursor + gap;
    r = -1;
    for (int c = cursor; c < s; c++)
      if ($urandom_range(0, 5) == 0) pd_a[c] = 1'b1;
    st_a[s] = 1'b1;
    clr_e[s+1] = 1'b1;
    if (mode <= 1) begin
      r = s + 1 + d;
      rx_hi = r;
      pd_a[r] = 1'b1;
      sen_e[r+1] = 1'b1;
      fe_a[r+2] = (mode == 1);
      if (mode == 0) ld_e[r+3] = 1'b1;
      end_c = (mode == 0) ? r + 4 : r + 3;
    end else if (mode == 2) begin
      rx_hi = s + 1 + T;
      to_e[s+2+T] = 1'b1;
      end_c = s + 2 + T;
    end else begin
      rx_hi = s + 1 + d;
      rs_a[rx_hi] = 1'b1;
      end_c = rx_hi + 1;
    end
    for (int c = s + 2; c <= rx_hi; c++) en_e[c] = 1'b1;
    // Ignored inputs: starts anywhere inside the frame, done outside RECEIVE.
    for (int c = s + 1; c < end_c; c++) begin
      if ($urandom_range(0, 7) == 0) st_a[c] = 1'b1;
      if ((c < s + 2 || c > rx_hi) && $urandom_range(0, 3) == 0) pd_a[c] = 1'b1;
    end
    cursor = end_c;
    r_out = r;
  endtask

  initial begin
    int r, rand_from, mode, d;

    for (int c = 0; c < N; c++) fe_a[c] = ($urandom_range(0, 1) == 1);
    rs_a[0] = 1'b1;
    rs_a[1] = 1'b1;
    cursor = 2;

    add_frame(0, 8, 3, r);            // first frame, start at cycle 5
    add_frame(0, 5, 2, r);            // second load over unread data
    rd_a[cursor + 2] = 1'b1;          // single read clears both flags
    cursor = cursor + 4;
    add_frame(0, 6, 1, r);
    add_frame(0, 7, 2, r);
    rd_a[r + 3] = 1'b1;               // read in the LOAD cycle
    add_frame(2, 0, 2, r);            // watchdog timeout
    add_frame(0, T, 1, r);            // done on the last counted cycle
    add_frame(1, 4, 2, r);            // framing error
    add_frame(3, 10, 1, r);           // reset mid-RECEIVE
    add_frame(0, 1, 0, r);            // shortest frame, immediately after reset
    add_frame(0, 3, 0, r);            // back-to-back at minimum spacing
    rand_from = cursor;

    while (cursor < N - 60) begin
      mode = int'($urandom_range(0, 9));
      if (mode <= 5) mode = 0;
      else if (mode <= 7) mode = 1;
      else if (mode == 8) mode = 2;
      else mode = 3;
      d = (mode == 3) ? int'($urandom_range(1, T - 1)) : int'($urandom_range(1, T));
      add_frame(mode, d, int'($urandom_range(0, 4)), r);
    end
    for (int c = rand_from; c < N; c++) rd_a[c] = ($urandom_range(0, 4) == 0);

    // Status flags from the host-side rules.
    rdy_e[0] = 1'b0;
    ovr_e[0] = 1'b0;
    for (int c = 0; c < N - 1; c++) begin
      if (rs_a[c]) begin
        rdy_e[c+1] = 1'b0;
        ovr_e[c+1] = 1'b0;
      end else begin
        rdy_e[c+1] = ld_e[c] ? 1'b1 : (rd_a[c] ? 1'b0 : rdy_e[c]);
        ovr_e[c+1] = (ld_e[c] && rdy_e[c] && !rd_a[c]) ? 1'b1 : (rd_a[c] ? 1'b0 : ovr_e[c]);
      end
    end

    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        chk("sbc_clear",     sbc_clear,     clr_e[c], c);
        chk("sbc_enable",    sbc_enable,    sen_e[c], c);
        chk("enable_timer",  enable_timer,  en_e[c],  c);
        chk("load_buffer",   load_buffer,   ld_e[c],  c);
        chk("timeout_error", timeout_error, to_e[c],  c);
        chk("data_ready",    data_ready,    rdy_e[c], c);
        chk("overrun_error", overrun_error, ovr_e[c], c);
      end
      rst                = rs_a[c];
      start_bit_detected = st_a[c];
      packet_done        = pd_a[c];
      framing_error      = fe_a[c];
      data_read          = rd_a[c];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_sequencer.md
# rx_sequencer

Receive-side control unit for the serial receiver. It watches the start-bit detector, enables and releases the bit timer for one frame, checks the stop bit, commands the receive buffer load, and keeps the host-facing `data_ready` and `overrun_error` status flags. It sits between the edge detector, bit timer and stop-bit checker on one side and the receive data buffer and host read interface on the other.

## Interface
- `TIMEOUT_CYCLES`, default 120: watchdog limit in clocks for the RECEIVE state; legal range 2..255.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_bit_detected`  in  1  one-cycle pulse on the falling edge of the serial line.
- `packet_done`  in  1  one-cycle pulse from the bit timer after 9 bit periods (8 data bits plus stop bit).
- `framing_error`  in  1  stop-bit checker result; valid from the cycle after `sbc_enable`.
- `data_read`  in  1  host read strobe, level-sampled each cycle.
- `sbc_clear`  out  1  clears the stop-bit checker.
- `sbc_enable`  out  1  latches the stop-bit checker.
- `enable_timer`  out  1  runs the bit timer; low clears it.
- `load_buffer`  out  1  one-cycle strobe that copies the shift register into the receive buffer.
- `data_ready`  out  1  the buffer holds unread data.
- `overrun_error`  out  1  a frame was loaded over unread data.
- `timeout_error`  out  1  one-cycle pulse when the watchdog aborts a frame.

## Operation
- FSM states: IDLE, CLEAR, RECEIVE, STOP_SET, STOP_CHK, LOAD.
- IDLE → CLEAR on `start_bit_detected`; otherwise stay in IDLE.
- CLEAR → RECEIVE unconditionally. `sbc_clear`=1 in CLEAR.
- RECEIVE: `enable_timer`=1. Go to STOP_SET on `packet_done`. Otherwise the watchdog counter increments each cycle.
- Watchdog timeout: when the counter reaches `TIMEOUT_CYCLES`-1 with no `packet_done`, go to IDLE and pulse `timeout_error` on that transition. `packet_done` in the same cycle takes priority over the timeout.
- STOP_SET → STOP_CHK. `sbc_enable`=1 in STOP_SET.
- STOP_CHK → IDLE if `framing_error`=1; no load occurs and the frame is silently dropped. Otherwise STOP_CHK → LOAD.
- LOAD → IDLE. `load_buffer`=1 in LOAD.
- `sbc_clear`, `sbc_enable`, `enable_timer` and `load_buffer` are Moore decodes of the state register, with no input-to-output paths.
- The watchdog counter is `$clog2(TIMEOUT_CYCLES)` bits wide. It is zeroed in every state other than RECEIVE, and it never wraps.
- `start_bit_detected` outside IDLE is ignored. `packet_done` outside RECEIVE is ignored.
- `data_ready` flag:
  - Set on the clock edge that leaves LOAD.
  - Cleared on any cycle with `data_read`=1 and no load.
  - If a load and `data_read` occur in the same cycle, `data_ready` stays 1.
- `overrun_error` flag:
  - Set when LOAD occurs with `data_ready`=1 and `data_read`=0.
  - Cleared by `data_read`.
  - Sticky otherwise.

## Timing
- Reset: state IDLE, counter 0. Every output is 0 in the cycle after `rst` is sampled high.
- `rst` mid-frame returns to IDLE at the next edge, regardless of inputs. `enable_timer` drops, which clears the timer.
- Start pulse sampled at edge t: `sbc_clear` high in cycle t+1, `enable_timer` high from t+2.
- `packet_done` sampled at edge r:
  - `enable_timer` low and `sbc_enable` high in cycle r+1.
  - STOP_CHK in cycle r+2.
  - `load_buffer` high in cycle r+3.
  - `data_ready` high from r+4, when the FSM is back in IDLE.
- Minimum frame-to-frame: a new `start_bit_detected` is accepted in IDLE from r+4.
- Timeout: `enable_timer` is high for exactly `TIMEOUT_CYCLES` cycles, then `timeout_error` pulses for 1 cycle as IDLE is entered.

## Structure
- Shared package `rx_pkg` holds:
  - the `rx_state_t` enum (3-bit, the six states above);
  - the `RX_TIMEOUT_DEFAULT`=120 constant.
- Sub-module `rx_watchdog`: a parameterized counter with clear and enable inputs and a `expired` output. It is instantiated once.
- The state register, next-state logic and status flags live in `rx_sequencer` itself.

## Test plan
- Clean frame: start pulse at cycle 5, `packet_done` at cycle 100, `framing_error`=0 → `sbc_clear` in cycle 6, `enable_timer` in 7..100, `sbc_enable` in 101, `load_buffer` in 103, `data_ready`=1 from 104.
- Framing error: same stimulus with `framing_error`=1 in cycle 102 → no `load_buffer` pulse, `data_ready` stays 0, FSM in IDLE at 103.
- Overrun: two clean frames with no `data_read` → `overrun_error`=1 after the second load. `data_read` for one cycle → both flags 0 on the next cycle.
- Simultaneous read and load: `data_read`=1 in the LOAD cycle while `data_ready`=1 → `data_ready` stays 1, `overrun_error` stays 0.
- Timeout: `TIMEOUT_CYCLES`=20, start pulse and no `packet_done` → `enable_timer` high for 20 cycles, then a 1-cycle `timeout_error` and return to IDLE. A `packet_done` on the last counted cycle goes to STOP_SET with no timeout.
- Reset mid-RECEIVE plus ignored starts: assert `rst` in cycle 50 of a frame → all outputs 0 at 51. Start pulses in RECEIVE → no state change.
